// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// type and the access-size helper.
package lsu_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // Access size in bytes; only funct3[1:0] matters (signedness is bit 2).
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] n;
        case (funct3[1:0])
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane steering: the addressed byte always sits in [63:56] of the
// doubleword, so loads take the top N bytes and stores replace the top N bytes.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] dword,
    input  logic [2:0]  funct3,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] merged_data
);

    logic is_unsigned;

    assign is_unsigned = funct3[2];

    // Extract/extend the load field and build the read-modify-write doubleword.
    always_comb begin
        load_data   = dword;
        merged_data = wdata;
        case (size_bytes(funct3))
            4'd1: begin
                load_data   = is_unsigned ? {56'd0, dword[63:56]}
                                          : {{56{dword[63]}}, dword[63:56]};
                merged_data = {wdata[7:0], dword[55:0]};
            end
            4'd2: begin
                load_data   = is_unsigned ? {48'd0, dword[63:48]}
                                          : {{48{dword[63]}}, dword[63:48]};
                merged_data = {wdata[15:0], dword[47:0]};
            end
            4'd4: begin
                load_data   = is_unsigned ? {32'd0, dword[63:32]}
                                          : {{32{dword[63]}}, dword[63:32]};
                merged_data = {wdata[31:0], dword[31:0]};
            end
            default: begin
                load_data   = dword;
                merged_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// Load/store unit master for a byte-addressed big-endian 64-bit data port.
// One request at a time; sub-doubleword stores are read-modify-write.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; faults go straight to ST_RESP
// ST_RD   | memory read strobe; doubleword captured at the exit edge
// ST_WR   | memory write strobe with the merged (or full SD) data
// ST_RESP | one-cycle response pulse, then back to ST_IDLE
module lsu_master
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 2048,
    parameter int XLEN      = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t state, state_nxt;

    logic            write_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            err_q;
    logic [XLEN-1:0] dword_q;

    logic [3:0]      req_size;
    logic [XLEN:0]   end_access;
    logic [XLEN:0]   end_window;
    logic            range_err;
    logic            misaligned;
    logic            req_fault;
    logic            accept;
    logic            sub_dword;

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged_data;

    assign req_size = size_bytes(req_funct3);

    // One extra bit so addresses near the top of the space cannot wrap past the limit.
    assign end_access = {1'b0, req_addr} + (XLEN+1)'(req_size);
    assign end_window = {1'b0, req_addr} + (XLEN+1)'(8);

    // Stores always read or write a full 8-byte window; loads only need their N bytes.
    assign range_err = req_write ? (end_window > (XLEN+1)'(MEM_BYTES))
                                 : (end_access > (XLEN+1)'(MEM_BYTES));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = |(req_addr[2:0] & (req_size[2:0] - 3'd1));
`else
    assign misaligned = 1'b0;
`endif

    assign req_fault = (req_funct3 == F3_ILL) | range_err | misaligned;
    assign accept    = req_valid & (state == ST_IDLE);
    assign sub_dword = (req_size != 4'd8);

    lsu_align u_align (
        .dword       (dword_q),
        .funct3      (funct3_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_data (merged_data)
    );

    // State register; reset abandons any in-flight access before its write edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch on accept and doubleword capture on leaving the read state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            dword_q  <= '0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= req_fault;
            end
            if (state == ST_RD) begin
                dword_q <= mem_rdata;
            end
        end
    end

    // Next-state and Moore outputs; strobes are decoded from state so they can never overlap.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault) begin
                        state_nxt = ST_RESP;
                    end else if (!req_write || sub_dword) begin
                        state_nxt = ST_RD;
                    end else begin
                        state_nxt = ST_WR;
                    end
                end
            end
            ST_RD: begin
                mem_read  = 1'b1;
                mem_addr  = addr_q;
                state_nxt = write_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merged_data;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (write_q || err_q) ? '0 : load_data;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_master.sv
// Bench for lsu_master: byte-array memory behind the port, a byte-level
// reference model, and a response scoreboard.
module tb_lsu_master;
    import lsu_pkg::*;

    localparam int MB = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_master #(.MEM_BYTES(MB), .XLEN(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        string       tag;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        int          acc;
        int          rd0;
        int          wr0;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int nrd = 0;
    int nwr = 0;
    bit both_seen = 1'b0;

    logic [7:0] mem   [0:MB-1] = '{7: 8'h08, default: 8'h00};
    logic [7:0] model [0:MB-1] = '{7: 8'h08, default: 8'h00};

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            if (mem_addr + 64'(i) < 64'(MB))
                mem_rdata[63-8*i -: 8] = mem[11'(mem_addr + 64'(i))];
        end
    end

    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_addr + 64'(i) < 64'(MB))
                    mem[11'(mem_addr + 64'(i))] <= mem_wdata[63-8*i -: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 8;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mem_read)  nrd++;
        if (mem_write) nwr++;
        if (mem_read && mem_write) both_seen = 1'b1;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_data"}, resp_rdata, e.rdata);
                chk({e.tag, "_err"}, 64'(resp_err), 64'(e.err));
                chk({e.tag, "_lat"}, 64'(cyc - e.acc + 1), 64'(e.lat));
                chk({e.tag, "_nrd"}, 64'(nrd - e.rd0), 64'(e.nrd));
                chk({e.tag, "_nwr"}, 64'(nwr - e.wr0), 64'(e.nwr));
            end
        end
    end

    task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd);
        exp_t e;
        int   n;
        int   t;
        bit   mis;
        n   = nbytes(f3);
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (a % 64'(n)) != 0;
`endif
        e.tag   = tag;
        e.err   = (f3 == 3'b111) || mis ||
                  (wr ? ({1'b0, a} + 65'd8 > 65'(MB)) : ({1'b0, a} + 65'(n) > 65'(MB)));
        e.rdata = '0;
        if (!e.err && !wr) begin
            for (int i = 0; i < n; i++)
                e.rdata = (e.rdata << 8) | {56'd0, model[11'(a + 64'(i))]};
            if (!f3[2] && n < 8 && e.rdata[8*n-1])
                e.rdata = e.rdata | (~64'd0 << (8*n));
        end
        if (!e.err && wr) begin
            for (int i = 0; i < n; i++)
                model[11'(a + 64'(i))] = wd[8*(n-1-i) +: 8];
        end
        e.lat = e.err ? 1 : ((wr && n < 8) ? 3 : 2);
        e.nrd = (!e.err && (!wr || n < 8)) ? 1 : 0;
        e.nwr = (!e.err && wr) ? 1 : 0;

        @(negedge clk);
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk({tag, "_ready_timeout"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = '1;
        req_addr  = '1;
        e.acc = cyc;
        e.rd0 = nrd;
        e.wr0 = nwr;
        sb.push_back(e);
        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk({tag, "_resp_timeout"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wr0;
        logic        rw;
        logic [2:0]  rf3;
        logic [63:0] ra;

        #22;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_err",   64'(resp_err), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_strb",  {62'd0, mem_read, mem_write}, 64'd0);
        chk("rst_addr",  mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_req("ld0",    1'b0, F3_D,  64'd0,  64'd0);
        chk("ld0_abs", resp_rdata, resp_rdata);
        n_cmp--;
        do_req("sb3",    1'b1, F3_B,  64'd3,  64'h0000_0000_0000_00AB);
        do_req("ld0b",   1'b0, F3_D,  64'd0,  64'd0);
        do_req("sh16",   1'b1, F3_H,  64'd16, 64'hFFFF_FFFF_FFFF_8001);
        do_req("lh16",   1'b0, F3_H,  64'd16, 64'd0);
        do_req("lhu16",  1'b0, F3_HU, 64'd16, 64'd0);
        do_req("lb17",   1'b0, F3_B,  64'd17, 64'd0);
        do_req("sd24",   1'b1, F3_D,  64'd24, 64'h1122_3344_5566_7788);
        do_req("lw24",   1'b0, F3_W,  64'd24, 64'd0);
        do_req("lwu28",  1'b0, F3_WU, 64'd28, 64'd0);
        do_req("ld2044", 1'b0, F3_D,  64'd2044, 64'd0);
        do_req("lw2",    1'b0, F3_W,  64'd2,  64'd0);
        do_req("ill",    1'b0, F3_ILL, 64'd8, 64'd0);
        do_req("sb2041", 1'b1, F3_B,  64'd2041, 64'h77);
        do_req("sb2040", 1'b1, F3_B,  64'd2040, 64'h9C);
        do_req("lb2040", 1'b0, F3_B,  64'd2040, 64'd0);
        do_req("lbu2047", 1'b0, F3_BU, 64'd2047, 64'd0);
        do_req("lh2047", 1'b0, F3_H,  64'd2047, 64'd0);
        do_req("ldhuge", 1'b0, F3_D,  64'hFFFF_FFFF_FFFF_FFFC, 64'd0);

        for (int i = 0; i < 24; i++) begin
            rw  = 1'($urandom_range(0, 1));
            rf3 = rw ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            ra  = (i % 4 == 0) ? 64'($urandom_range(MB - 10, MB - 1)) : 64'($urandom_range(0, 63));
            do_req("rnd", rw, rf3, ra, {$urandom, $urandom});
        end

        @(negedge clk);
        req_write  = 1'b1;
        req_funct3 = F3_B;
        req_addr   = 64'd40;
        req_wdata  = 64'h5A;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wr0 = nwr;
        chk("rst_mid_inrd", 64'(mem_read), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rstm_ready", 64'(req_ready), 64'd1);
        chk("rstm_valid", 64'(resp_valid), 64'd0);
        chk("rstm_strb",  {62'd0, mem_read, mem_write}, 64'd0);
        chk("rstm_addr",  mem_addr, 64'd0);
        chk("rstm_wdata", mem_wdata, 64'd0);
        chk("rstm_rdata", resp_rdata, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstm_nowrite", 64'(nwr - wr0), 64'd0);
        chk("rstm_ready2", 64'(req_ready), 64'd1);
        do_req("lb40", 1'b0, F3_B, 64'd40, 64'd0);

        chk("strobe_excl", 64'(both_seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
